// File: rtl/overlap_add_stage.sv
// Overlap-add stage: sums the two oldest delay-line taps per lane behind a valid/ready
// output register, tracks line fill and row position. Optional macro: OVERLAP_SAT_EN.
module overlap_add_stage #(
   parameter int unsigned PARAKRN = 64,
   parameter int unsigned DATALEN = 6,
   parameter int unsigned DELYNUM = 6,
   parameter int unsigned ROWLEN  = 32
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           flush,
   input  logic [DATALEN*PARAKRN-1:0]     tap_n_minus_1,
   input  logic [DATALEN*PARAKRN-1:0]     tap_n,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [(DATALEN+1)*PARAKRN-1:0] out_sum,
   output logic                           out_last,
   output logic                           fill_done
);

   localparam int unsigned SumW  = DATALEN + 1;
   localparam int unsigned FillW = $clog2(DELYNUM + 1);
   localparam int unsigned ColW  = (ROWLEN > 1) ? $clog2(ROWLEN) : 1;

   logic [FillW-1:0]         fill_cnt_q, fill_cnt_d;
   logic [ColW-1:0]          col_cnt_q, col_cnt_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [SumW*PARAKRN-1:0]  out_sum_q, out_sum_d;
   logic [SumW*PARAKRN-1:0]  lane_sums;
   logic                     push;
   logic                     capture;
   logic                     col_last;

   assign fill_done = (fill_cnt_q == FillW'(DELYNUM));
   assign in_ready  = (!out_valid_q || out_ready) && !flush;
   assign push      = in_valid && in_ready;
   assign capture   = push && fill_done;
   assign col_last  = (col_cnt_q == ColW'(ROWLEN - 1));

   for (genvar g = 0; g < PARAKRN; g++) begin : g_lane
      logic signed [SumW-1:0] a;
      logic signed [SumW-1:0] b;
      logic signed [SumW-1:0] s;

      assign a = {tap_n_minus_1[g*DATALEN+DATALEN-1], tap_n_minus_1[g*DATALEN +: DATALEN]};
      assign b = {tap_n[g*DATALEN+DATALEN-1], tap_n[g*DATALEN +: DATALEN]};
      assign s = a + b;

`ifdef OVERLAP_SAT_EN
      // Top two bits disagree only when the sum left the DATALEN-bit range.
      assign lane_sums[g*SumW +: SumW] = (s[SumW-1] != s[SumW-2]) ?
                                         {s[SumW-1], s[SumW-1], {(SumW-2){~s[SumW-1]}}} : s;
`else
      assign lane_sums[g*SumW +: SumW] = s;
`endif
   end

   always_comb begin
      fill_cnt_d  = fill_cnt_q;
      col_cnt_d   = col_cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_sum_d   = out_sum_q;

      if (flush) begin
         // Line contents survive a flush; re-priming overwrites them.
         fill_cnt_d  = '0;
         col_cnt_d   = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         if (push && !fill_done) begin
            fill_cnt_d = fill_cnt_q + FillW'(1);
         end
         if (capture) begin
            out_valid_d = 1'b1;
            out_sum_d   = lane_sums;
            out_last_d  = col_last;
            col_cnt_d   = col_last ? '0 : col_cnt_q + ColW'(1);
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fill_cnt_q  <= '0;
         col_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_sum_q   <= '0;
      end else begin
         fill_cnt_q  <= fill_cnt_d;
         col_cnt_q   <= col_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_sum_q   <= out_sum_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_overlap_add_stage.sv
// Directed bench for overlap_add_stage with a behavioural two-tap delay line in front.
module tb_overlap_add_stage;

   localparam int PARAKRN = 8;
   localparam int DATALEN = 6;
   localparam int DELYNUM = 6;
   localparam int ROWLEN  = 4;
   localparam int LW      = PARAKRN * DATALEN;
   localparam int OW      = PARAKRN * (DATALEN + 1);

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [LW-1:0] in_data;
   logic [LW-1:0] tap_n_minus_1;
   logic [LW-1:0] tap_n;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_sum;
   logic          out_last;
   logic          fill_done;
   logic [LW-1:0] line [DELYNUM];
   logic [OW-1:0] held;

   int checks;
   int errors;

   overlap_add_stage #(
      .PARAKRN(PARAKRN),
      .DATALEN(DATALEN),
      .DELYNUM(DELYNUM),
      .ROWLEN (ROWLEN)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .tap_n_minus_1(tap_n_minus_1),
      .tap_n        (tap_n),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_last     (out_last),
      .fill_done    (fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Delay line model: line[0] holds the newest push.
   always @(posedge clk) begin
      if (in_valid && in_ready) begin
         line[0] <= in_data;
         for (int k = 1; k < DELYNUM; k++) line[k] <= line[k-1];
      end
   end
   assign tap_n         = line[DELYNUM-1];
   assign tap_n_minus_1 = line[DELYNUM-2];

   function automatic logic [LW-1:0] tap_vec(input int v, input int step);
      logic [LW-1:0] r;
      int x;
      for (int i = 0; i < PARAKRN; i++) begin
         x = v + step * i;
         r[i*DATALEN +: DATALEN] = x[DATALEN-1:0];
      end
      return r;
   endfunction

   function automatic logic [OW-1:0] exp_vec(input int s, input int step);
      logic [OW-1:0] r;
      int x;
      for (int i = 0; i < PARAKRN; i++) begin
         x = s + step * i;
`ifdef OVERLAP_SAT_EN
         if (x > 31) x = 31;
         if (x < -32) x = -32;
`endif
         r[i*(DATALEN+1) +: DATALEN+1] = x[DATALEN:0];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v, input int step);
      in_data  = tap_vec(v, step);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || fill_done !== 1'b0 || out_sum !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b l=%b f=%b s=%h want all 0",
                  out_valid, out_last, fill_done, out_sum);
      end
      tick();
      tick();
      rstn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_priming();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (fill_done !== (k >= DELYNUM)) begin
            errors++;
            $display("FAIL prime_fill_done k=%0d got %b want %b", k, fill_done, k >= DELYNUM);
         end
         push(k, 0);
         checks++;
         if (out_valid !== (k >= DELYNUM)) begin
            errors++;
            $display("FAIL prime_valid k=%0d got %b want %b", k, out_valid, k >= DELYNUM);
         end
      end
      checks++;
      if (out_sum !== exp_vec(3, 0)) begin
         errors++;
         $display("FAIL prime_sum7 got %h want %h", out_sum, exp_vec(3, 0));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL prime_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_sign_ext();
      int vals [9] = '{-32, -32, 31, 31, 0, 0, 0, 0, 0};
      int exps [3] = '{-64, -1, 62};
      do_flush();
      checks++;
      if (fill_done !== 1'b0) begin
         errors++;
         $display("FAIL sext_flush_fill got %b want 0", fill_done);
      end
      for (int k = 0; k < 9; k++) begin
         push(vals[k], 0);
         if (k >= DELYNUM) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== exp_vec(exps[k-DELYNUM], 0)) begin
               errors++;
               $display("FAIL sext_sum k=%0d got v=%b %h want %h", k, out_valid, out_sum,
                        exp_vec(exps[k-DELYNUM], 0));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_flush();
      for (int k = 0; k < 7; k++) push(10 + k, 1);
      held = exp_vec(21, 2);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== held) begin
         errors++;
         $display("FAIL bp_first got v=%b %h want %h", out_valid, out_sum, held);
      end
      out_ready = 1'b0;
      in_data   = tap_vec(17, 1);
      in_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held || fill_done !== 1'b1)
         begin
            errors++;
            $display("FAIL bp_stall c=%0d got rdy=%b v=%b f=%b %h want rdy=0 v=1 f=1 %h",
                     c, in_ready, out_valid, fill_done, out_sum, held);
         end
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      for (int k = 7; k < 10; k++) begin
         in_data  = tap_vec(10 + k, 1);
         in_valid = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== exp_vec(2 * k + 9, 2)) begin
            errors++;
            $display("FAIL bp_release k=%0d got v=%b %h want %h", k, out_valid, out_sum,
                     exp_vec(2 * k + 9, 2));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_row_wrap();
      do_flush();
      for (int k = 0; k < DELYNUM; k++) push(k, 0);
      for (int j = 0; j < 10; j++) begin
         push(DELYNUM + j, 0);
         checks++;
         if (out_valid !== 1'b1 || out_last !== (j == 3 || j == 7) ||
             out_sum !== exp_vec(2 * j + 1, 0)) begin
            errors++;
            $display("FAIL row_out j=%0d got v=%b last=%b %h want last=%b %h", j, out_valid,
                     out_last, out_sum, (j == 3 || j == 7), exp_vec(2 * j + 1, 0));
         end
      end
      checks++;
      if (dut.col_cnt_q !== 2'd2) begin
         errors++;
         $display("FAIL row_col_cnt got %0d want 2", dut.col_cnt_q);
      end
   endtask

   task automatic test_flush_collision();
      out_ready = 1'b0;
      flush     = 1'b1;
      in_data   = tap_vec(5, 0);
      in_valid  = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_ready got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || fill_done !== 1'b0 || dut.col_cnt_q !== 2'd0) begin
         errors++;
         $display("FAIL flush_state got v=%b f=%b col=%0d want 0 0 0", out_valid, fill_done,
                  dut.col_cnt_q);
      end
      out_ready = 1'b1;
      for (int k = 0; k < DELYNUM; k++) begin
         push(k, 1);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_reprime k=%0d got %b want 0", k, out_valid);
         end
      end
      push(DELYNUM, 1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== exp_vec(1, 2)) begin
         errors++;
         $display("FAIL flush_first got v=%b %h want %h", out_valid, out_sum, exp_vec(1, 2));
      end
   endtask

   task automatic test_async_reset();
      push(DELYNUM + 1, 1);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre got %b want 1", out_valid);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || fill_done !== 1'b0 || out_sum !== '0) begin
         errors++;
         $display("FAIL arst_outputs got v=%b l=%b f=%b s=%h want all 0",
                  out_valid, out_last, fill_done, out_sum);
      end
      tick();
      rstn = 1'b1;
      for (int k = 0; k < DELYNUM; k++) begin
         push(20 + k, -1);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_reprime k=%0d got %b want 0", k, out_valid);
         end
      end
      push(20 + DELYNUM, -1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== exp_vec(41, -2)) begin
         errors++;
         $display("FAIL arst_first got v=%b %h want %h", out_valid, out_sum, exp_vec(41, -2));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      test_reset();
      test_priming();
      test_sign_ext();
      test_backpressure();
      test_row_wrap();
      test_flush_collision();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/overlap_add_stage.md
# overlap_add_stage

- Sits directly downstream of the two-tap delay line in the frequency-domain convolution datapath.
- Combines the line's two oldest taps (pushes n-1 and n back) element-wise across all PARAKRN lanes to produce the overlap-add result.
- Tracks delay-line fill, which the line itself does not report.
- Paces the shared push strobe through a valid/ready handshake and marks row boundaries for the downstream accumulator.

## Interface
- PARAKRN, 64, parallel lanes; must match the delay line
- DATALEN, 6, signed lane width on the taps
- DELYNUM, 6, delay-line depth; must match the delay line; minimum 2
- ROWLEN, 32, outputs per row; minimum 1
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a vector to push
- in_ready  out  1  push accepted when in_valid&&in_ready; also drives the delay line's valid
- flush  in  1  synchronous restart for a new frame
- tap_n_minus_1  in  DATALEN×PARAKRN  delay line outdata_after_n_minus_1
- tap_n  in  DATALEN×PARAKRN  delay line outdata_after_n
- out_valid  out  1  out_sum holds a result
- out_ready  in  1  downstream accepts
- out_sum  out  (DATALEN+1)×PARAKRN  per-lane sum
- out_last  out  1  qualifies out_sum as last of a row
- fill_done  out  1  delay line fully primed

## Operation
- Push = in_valid && in_ready && !flush.
- in_ready = (!out_valid || out_ready) && !flush.
  - Combinational.
  - Does not depend on in_valid.
- fill_cnt, 0..DELYNUM:
  - Increments on each push.
  - Saturates at DELYNUM.
  - fill_done = (fill_cnt == DELYNUM).
- Capture:
  - A push with fill_done=1 loads out_sum from the taps as they are in that same cycle, before the line shifts.
  - out_valid is set on capture.
  - Pushes with fill_done=0 only prime the line; nothing is emitted.
- Result: the p-th push (p ≥ DELYNUM, 0-based) emits the lane-wise sum of pushes p-DELYNUM+1 and p-DELYNUM.
- Arithmetic:
  - Two's complement.
  - Each tap is sign-extended to DATALEN+1 bits, then added.
  - The sum cannot overflow.
- out_valid:
  - Clears when out_ready=1 and no capture occurs in that cycle.
  - Capture and drain in the same cycle keep out_valid=1 with the new data.
- out_sum and out_last are held stable while out_valid && !out_ready.
- col_cnt, 0..ROWLEN-1:
  - Counts captures.
  - out_last = (col_cnt == ROWLEN-1) for the captured word.
  - Wraps to 0 after the last word.
  - ROWLEN=1 gives out_last on every output.
- flush:
  - Clears fill_cnt, col_cnt and out_valid at the edge.
  - Has priority over push and drain in the same cycle.
  - Any pending output is discarded.
  - The delay line contents are not cleared; re-priming rewrites them.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_sum=0, fill_done=0.
  - fill_cnt=0, col_cnt=0.
  - in_ready=1 after reset release, provided flush=0.
- Latency: the output is registered 1 cycle after the accepting push edge.
- Throughput: one result per cycle with out_ready held high.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0, stalling both the line and upstream.
- Async reset mid-frame: all state drops immediately; the first DELYNUM pushes after release are treated as priming.

## Configuration
- OVERLAP_SAT_EN defined:
  - Each lane sum is clamped to [-2^(DATALEN-1), 2^(DATALEN-1)-1].
  - The clamped value is sign-extended into the DATALEN+1-bit field.
  - Clamping is combinational before the output register; it adds no latency.
- OVERLAP_SAT_EN undefined: the full DATALEN+1-bit sum is output.
- Handshake and counters are identical in both builds.

## Test plan
- Priming:
  - Stimulus: reset, then push vectors with every lane = k for k=0..7, DELYNUM=6.
  - Response: no out_valid for pushes 0..5; fill_done=1 after the 6th.
  - Push 6 yields lanes=1 (1+0); push 7 yields 3 (2+1).
- Sign extension:
  - Stimulus: taps -32 and -32 (DATALEN=6).
  - Response: out_sum=-64 without the macro; -32 with OVERLAP_SAT_EN.
  - Stimulus: taps 31+31.
  - Response: 62 without the macro; 31 with it.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
  - Response: in_ready=0, out_sum stable, fill_cnt unchanged, no data lost.
  - On release: back-to-back outputs continue at 1 per cycle.
- Row wrap:
  - Stimulus: ROWLEN=4, 10 results emitted.
  - Response: out_last on results 3 and 7 only; col_cnt=2 at the end.
- Flush collision:
  - Stimulus: flush asserted with in_valid=1, out_valid=1, out_ready=0.
  - Response: in_ready=0 in that cycle; next cycle out_valid=0, fill_done=0, col_cnt=0.
  - The next 6 pushes re-prime with no output.
- Async reset mid-frame:
  - Stimulus: rstn low for 1 cycle during streaming.
  - Response: all outputs 0 immediately; priming restarts.
